// File: rtl/mux_arb_n_if.sv
// Handshake bundle for mux_arb_n: N producer channels in, one registered
// consumer channel out.
interface mux_arb_n_if #(
  parameter int WIDTH = 1,
  parameter int N     = 4,
  parameter int SELW  = 2
);
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_chan;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data,
    output in_valid,
    output mode,
    output sel,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_chan,
    input  out_valid
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  mode,
    input  sel,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_chan,
    output out_valid
  );
endinterface

// File: rtl/mux_arb_n.sv
// N-channel registered mux with fixed-select or round-robin arbitration
// and a one-entry valid/ready output register.
module mux_arb_n #(
  parameter int WIDTH = 1,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input logic        clk,
  input logic        reset,
  mux_arb_n_if.slave bus
);

  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  rr_ptr_nxt;
  logic             accept;
  logic             fx_hit;
  logic             hi_hit;
  logic             lo_hit;
  logic [SELW-1:0]  hi_g;
  logic [SELW-1:0]  lo_g;
  logic             grant_valid;
  logic [SELW-1:0]  g;
  logic [WIDTH-1:0] g_data;
  logic             xfer;

  assign accept = ~bus.out_valid | bus.out_ready;

  // Round-robin: lowest valid at/after rr_ptr wins, else lowest valid
  // overall (the wrapped part of the scan).
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_g   = '0;
    lo_g   = '0;
    fx_hit = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) begin
        lo_hit = 1'b1;
        lo_g   = SELW'(i);
        if (i >= int'(rr_ptr)) begin
          hi_hit = 1'b1;
          hi_g   = SELW'(i);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (int'(bus.sel) == i && bus.in_valid[i])
        fx_hit = 1'b1;
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    g           = bus.sel;
    if (bus.mode) begin
      grant_valid = hi_hit | lo_hit;
      g           = hi_hit ? hi_g : lo_g;
    end else begin
      grant_valid = fx_hit;
    end
  end

  assign xfer = accept & grant_valid & ~reset;

  always_comb begin
    bus.in_ready = '0;
    g_data       = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(g) == i) begin
        bus.in_ready[i] = xfer;
        g_data          = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign rr_ptr_nxt = (g == SELW'(N - 1)) ? '0 : g + SELW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_chan  <= '0;
      rr_ptr        <= '0;
    end else if (xfer) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= g_data;
      bus.out_chan  <= g;
      if (bus.mode)
        rr_ptr <= rr_ptr_nxt;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed vector bench for mux_arb_n (N=4, WIDTH=8, SELW=2).
module tb_mux_arb_n;

  logic clk;
  logic reset;
  int   ncmp;
  int   nbad;

  mux_arb_n_if #(.WIDTH(8), .N(4), .SELW(2)) bus ();

  mux_arb_n #(.WIDTH(8), .N(4), .SELW(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  iv;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  eir;
    logic        eov;
    logic [7:0]  eod;
    logic [1:0]  eoc;
  } vec_t;

  vec_t v[$];

  localparam logic [31:0] D5A = 32'h005A_0000;
  localparam logic [31:0] DRR = 32'h1312_1110;

  function automatic vec_t mk(
    logic rst, logic mode, logic [1:0] sel, logic [3:0] iv,
    logic [31:0] data, logic ordy, logic [3:0] eir,
    logic eov, logic [7:0] eod, logic [1:0] eoc);
    vec_t r;
    r.rst = rst; r.mode = mode; r.sel = sel; r.iv = iv;
    r.data = data; r.ordy = ordy; r.eir = eir;
    r.eov = eov; r.eod = eod; r.eoc = eoc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    reset         = x.rst;
    bus.mode      = x.mode;
    bus.sel       = x.sel;
    bus.in_valid  = x.iv;
    bus.in_data   = x.data;
    bus.out_ready = x.ordy;
  endtask

  initial begin
    int k;
    ncmp = 0;
    nbad = 0;

    // reset, fixed mode sel=2
    v.push_back(mk(1, 0, 2, 4'b0100, D5A, 1, 4'b0000, 0, 8'h00, 0));
    v.push_back(mk(1, 0, 2, 4'b0100, D5A, 1, 4'b0000, 0, 8'h00, 0));
    v.push_back(mk(0, 0, 2, 4'b0100, D5A, 1, 4'b0100, 1, 8'h5A, 2));
    // fixed mode, selected channel idle -> drain
    v.push_back(mk(0, 0, 3, 4'b0101, D5A, 1, 4'b0000, 0, 8'h5A, 2));
    // round-robin fairness, 8 back-to-back words
    for (int i = 0; i < 8; i++)
      v.push_back(mk(0, 1, 0, 4'b1111, DRR, 1, 4'(1 << (i % 4)), 1,
                     8'(8'h10 + i % 4), 2'(i % 4)));
    // move rr_ptr to 1, then skip to 3, wrap to 0
    v.push_back(mk(0, 1, 0, 4'b1111, DRR, 1, 4'b0001, 1, 8'h10, 0));
    v.push_back(mk(0, 1, 0, 4'b1001, DRR, 1, 4'b1000, 1, 8'h13, 3));
    v.push_back(mk(0, 1, 0, 4'b1001, DRR, 1, 4'b0001, 1, 8'h10, 0));
    // backpressure 3 cycles, then release (rr_ptr=1)
    for (int i = 0; i < 3; i++)
      v.push_back(mk(0, 1, 0, 4'b1111, DRR, 0, 4'b0000, 1, 8'h10, 0));
    v.push_back(mk(0, 1, 0, 4'b1111, DRR, 1, 4'b0010, 1, 8'h11, 1));
    // fixed-mode transfer leaves rr_ptr at 2
    v.push_back(mk(0, 0, 1, 4'b1111, DRR, 1, 4'b0010, 1, 8'h11, 1));
    v.push_back(mk(0, 1, 0, 4'b1111, DRR, 1, 4'b0100, 1, 8'h12, 2));
    // stall, reset mid-stall, restart at channel 0
    v.push_back(mk(0, 1, 0, 4'b1111, DRR, 0, 4'b0000, 1, 8'h12, 2));
    v.push_back(mk(1, 1, 0, 4'b1111, DRR, 0, 4'b0000, 0, 8'h00, 0));
    v.push_back(mk(0, 1, 0, 4'b1111, DRR, 1, 4'b0001, 1, 8'h10, 0));
    // drain with no producers: data/chan hold
    v.push_back(mk(0, 1, 0, 4'b0000, DRR, 1, 4'b0000, 0, 8'h10, 0));

    drive(v[0]);
    foreach (v[i]) begin
      drive(v[i]);
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(v[i].eir));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(v[i].eov));
      chk($sformatf("v%0d out_data", i), 32'(bus.out_data), 32'(v[i].eod));
      chk($sformatf("v%0d out_chan", i), 32'(bus.out_chan), 32'(v[i].eoc));
      @(negedge clk);
    end

    // Fill from empty under backpressure, then hold while new words wait
    reset = 0;
    bus.mode = 0;
    bus.sel = 1;
    bus.in_valid = 4'b0010;
    bus.in_data = DRR;
    bus.out_ready = 0;
    k = 0;
    @(posedge clk);
    #1;
    while (!bus.out_valid && k < 5) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("hs fill out_valid", 32'(bus.out_valid), 32'd1);
    chk("hs fill out_chan", 32'(bus.out_chan), 32'd1);
    chk("hs fill out_data", 32'(bus.out_data), 32'h11);
    @(negedge clk);
    bus.in_valid = 4'b1111;
    bus.in_data = 32'hA3A2_A1A0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("hs stall%0d in_ready", i), 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("hs stall%0d out_data", i), 32'(bus.out_data), 32'h11);
      chk($sformatf("hs stall%0d out_chan", i), 32'(bus.out_chan), 32'd1);
      @(negedge clk);
    end
    bus.out_ready = 1;
    #1;
    chk("hs release in_ready", 32'(bus.in_ready), 32'b0010);
    @(posedge clk);
    #1;
    chk("hs release out_data", 32'(bus.out_data), 32'hA1);
    chk("hs release out_valid", 32'(bus.out_valid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
